// File: rtl/hsid_pkg.sv
// ---------------------------------------------------------------------------
// hsid_pkg
// Shared types and constants for the HSID divider arbiter slice.
//   hsid_div_arb_state_t : arbiter FSM states
//   HSID_DIV_ARB_NUM_REQ : default requester count
//   HSID_HSP_LIBRARY_WIDTH : default HSP reference tag width
//   hsid_idx_width()     : index width for an N-entry one-hot (min 1 bit)
// ---------------------------------------------------------------------------
package hsid_pkg;

  localparam int HSID_DIV_ARB_NUM_REQ   = 4;
  localparam int HSID_HSP_LIBRARY_WIDTH = 8;

  typedef enum logic [2:0] {
    HDA_IDLE,
    HDA_ISSUE,
    HDA_WAIT,
    HDA_RESP,
    HDA_FLUSH
  } hsid_div_arb_state_t;

  function automatic int hsid_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hsid_rr_arbiter.sv
// ---------------------------------------------------------------------------
// hsid_rr_arbiter
// Combinational round-robin arbiter. The search starts at ptr_i+1 (wrapping),
// so the requester granted last has the lowest priority next time.
// Ports:
//   req_i   [N]  request vector
//   ptr_i   [IW] index of the most recently granted requester
//   en_i         grant enable; when low no grant is produced
//   grant_o [N]  one-hot (or zero) grant
//   idx_o   [IW] index of the granted requester (0 when no grant)
//   valid_o      any grant present
// ---------------------------------------------------------------------------
module hsid_rr_arbiter
  import hsid_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = hsid_idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0]  hi_mask;
  logic [N-1:0]  req_hi;
  logic [N-1:0]  pick_src;
  logic [N-1:0]  pick_lsb;
  logic [IW-1:0] idx_chain [N+1];

  // Requesters strictly above the pointer take precedence; if none of them
  // is asking, the search wraps to the lowest index overall.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign hi_mask[gi] = (IW'(gi) > ptr_i);
  end

  assign req_hi   = req_i & hi_mask;
  assign pick_src = (|req_hi) ? req_hi : req_i;
  // Isolate the lowest set bit.
  assign pick_lsb = pick_src & (~pick_src + N'(1));
  assign grant_o  = en_i ? pick_lsb : '0;
  assign valid_o  = |grant_o;

  // One-hot to index encoder built as an OR chain.
  assign idx_chain[0] = '0;
  for (genvar gi = 0; gi < N; gi++) begin : g_enc
    assign idx_chain[gi+1] = idx_chain[gi] | (grant_o[gi] ? IW'(gi) : '0);
  end
  assign idx_o = idx_chain[N];

endmodule

// File: rtl/hsid_div_arbiter.sv
// ---------------------------------------------------------------------------
// hsid_div_arbiter
// Shares one hsid_divider among NUM_REQ requesters. One operation is in
// flight at a time: grant -> div_start pulse -> wait div_done -> hold the
// tagged result on a valid/ready response channel.
// Optional watchdog: define HSID_DIV_ARB_TIMEOUT_EN to bound WAIT at
// TIMEOUT_CYCLES; an expired wait returns an all-ones, overflow-flagged
// response with resp_timeout_o=1 and then flushes the divider.
// Ports:
//   clk, rst (async, active high), clear_i (synchronous abort)
//   req_valid_i/req_ready_o     per-requester handshake
//   req_dividend_i/divisor_i/of_i/hsp_ref_i  packed per-requester operands
//   resp_valid_o/resp_ready_i   response handshake
//   resp_id_o, resp_quotient_o, resp_remainder_o, resp_overflow_o,
//   resp_hsp_ref_o, resp_timeout_o  response payload
//   div_*_o / div_*_i           divider interface
//   busy_o                      FSM not idle
// ---------------------------------------------------------------------------
module hsid_div_arbiter
  import hsid_pkg::*;
#(
  parameter  int NUM_REQ           = HSID_DIV_ARB_NUM_REQ,
  parameter  int K                 = 32,
  parameter  int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
  parameter  int TIMEOUT_CYCLES    = 2*K+8,
  localparam int IW                = hsid_idx_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*2*K-1:0]         req_dividend_i,
  input  logic [NUM_REQ*K-1:0]           req_divisor_i,
  input  logic [NUM_REQ-1:0]             req_of_i,
  input  logic [NUM_REQ*HSP_LIBRARY_WIDTH-1:0] req_hsp_ref_i,
  output logic                           resp_valid_o,
  input  logic                           resp_ready_i,
  output logic [IW-1:0]                  resp_id_o,
  output logic [K-1:0]                   resp_quotient_o,
  output logic [K-1:0]                   resp_remainder_o,
  output logic                           resp_overflow_o,
  output logic [HSP_LIBRARY_WIDTH-1:0]   resp_hsp_ref_o,
  output logic                           resp_timeout_o,
  output logic                           div_start_o,
  output logic                           div_clear_o,
  output logic [2*K-1:0]                 div_dividend_o,
  output logic [K-1:0]                   div_divisor_o,
  output logic                           div_of_o,
  output logic [HSP_LIBRARY_WIDTH-1:0]   div_hsp_ref_o,
  input  logic                           div_ready_i,
  input  logic                           div_done_i,
  input  logic                           div_overflow_i,
  input  logic [K-1:0]                   div_quotient_i,
  input  logic [K-1:0]                   div_remainder_i,
  input  logic [HSP_LIBRARY_WIDTH-1:0]   div_hsp_ref_out_i,
  output logic                           busy_o
);

  localparam int HW = HSP_LIBRARY_WIDTH;

  hsid_div_arb_state_t state_q;
  logic [IW-1:0]  ptr_q;
  logic [IW-1:0]  id_q;
  logic [2*K-1:0] dividend_q;
  logic [K-1:0]   divisor_q;
  logic           of_q;
  logic [HW-1:0]  hsp_q;
  logic           div_start_q;
  logic           div_clear_q;
  logic           resp_valid_q;
  logic [K-1:0]   resp_quot_q;
  logic [K-1:0]   resp_rem_q;
  logic           resp_ovf_q;
  logic [HW-1:0]  resp_hsp_q;

`ifdef HSID_DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]  wd_cnt_q;
  logic           resp_timeout_q;
`endif

  // ---- grant -------------------------------------------------------------
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_valid;
  logic               arb_en;

  // Grants only when the divider can take a new operation and no abort is
  // pending this cycle.
  assign arb_en = (state_q == HDA_IDLE) && div_ready_i && !clear_i;

  hsid_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .valid_o (grant_valid)
  );

  assign req_ready_o = grant;

  // ---- operand select (AND-OR mux keyed by the one-hot grant) ------------
  logic [2*K-1:0] dvd_chain [NUM_REQ+1];
  logic [K-1:0]   dvs_chain [NUM_REQ+1];
  logic           of_chain  [NUM_REQ+1];
  logic [HW-1:0]  hsp_chain [NUM_REQ+1];

  assign dvd_chain[0] = '0;
  assign dvs_chain[0] = '0;
  assign of_chain[0]  = 1'b0;
  assign hsp_chain[0] = '0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
    assign dvd_chain[gi+1] = dvd_chain[gi] |
                             ({(2*K){grant[gi]}} & req_dividend_i[gi*2*K +: 2*K]);
    assign dvs_chain[gi+1] = dvs_chain[gi] |
                             ({K{grant[gi]}} & req_divisor_i[gi*K +: K]);
    assign of_chain[gi+1]  = of_chain[gi] | (grant[gi] & req_of_i[gi]);
    assign hsp_chain[gi+1] = hsp_chain[gi] |
                             ({HW{grant[gi]}} & req_hsp_ref_i[gi*HW +: HW]);
  end

  // ---- control FSM -------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HDA_IDLE;
      ptr_q        <= IW'(NUM_REQ - 1);
      id_q         <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      of_q         <= 1'b0;
      hsp_q        <= '0;
      div_start_q  <= 1'b0;
      div_clear_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_quot_q  <= '0;
      resp_rem_q   <= '0;
      resp_ovf_q   <= 1'b0;
      resp_hsp_q   <= '0;
`ifdef HSID_DIV_ARB_TIMEOUT_EN
      wd_cnt_q       <= '0;
      resp_timeout_q <= 1'b0;
`endif
    end else begin
      div_start_q <= 1'b0;
      div_clear_q <= 1'b0;
      if (clear_i) begin
        // Abort wins over everything, including a coincident div_done.
        div_clear_q  <= 1'b1;
        resp_valid_q <= 1'b0;
        state_q      <= HDA_FLUSH;
      end else begin
        case (state_q)
          HDA_IDLE: begin
            if (grant_valid) begin
              dividend_q  <= dvd_chain[NUM_REQ];
              divisor_q   <= dvs_chain[NUM_REQ];
              of_q        <= of_chain[NUM_REQ];
              hsp_q       <= hsp_chain[NUM_REQ];
              id_q        <= grant_idx;
              ptr_q       <= grant_idx;
              div_start_q <= 1'b1;
              state_q     <= HDA_ISSUE;
            end
          end
          HDA_ISSUE: begin
`ifdef HSID_DIV_ARB_TIMEOUT_EN
            wd_cnt_q <= '0;
`endif
            state_q <= HDA_WAIT;
          end
          HDA_WAIT: begin
            if (div_done_i) begin
              resp_quot_q  <= div_quotient_i;
              resp_rem_q   <= div_remainder_i;
              resp_ovf_q   <= div_overflow_i;
              resp_hsp_q   <= div_hsp_ref_out_i;
              resp_valid_q <= 1'b1;
`ifdef HSID_DIV_ARB_TIMEOUT_EN
              resp_timeout_q <= 1'b0;
`endif
              state_q      <= HDA_RESP;
            end
`ifdef HSID_DIV_ARB_TIMEOUT_EN
            else if (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
              // Divider is stuck: abort it and report a poisoned result
              // carrying the request's own tag.
              div_clear_q    <= 1'b1;
              resp_quot_q    <= '1;
              resp_rem_q     <= '1;
              resp_ovf_q     <= 1'b1;
              resp_hsp_q     <= hsp_q;
              resp_timeout_q <= 1'b1;
              resp_valid_q   <= 1'b1;
              state_q        <= HDA_RESP;
            end else begin
              wd_cnt_q <= wd_cnt_q + CW'(1);
            end
`endif
          end
          HDA_RESP: begin
            if (resp_ready_i) begin
              resp_valid_q <= 1'b0;
`ifdef HSID_DIV_ARB_TIMEOUT_EN
              state_q <= resp_timeout_q ? HDA_FLUSH : HDA_IDLE;
`else
              state_q <= HDA_IDLE;
`endif
            end
          end
          HDA_FLUSH: begin
            if (div_ready_i) begin
              state_q <= HDA_IDLE;
            end
          end
          default: state_q <= HDA_IDLE;
        endcase
      end
    end
  end

  // ---- outputs -----------------------------------------------------------
  assign div_start_o      = div_start_q;
  assign div_clear_o      = div_clear_q;
  assign div_dividend_o   = dividend_q;
  assign div_divisor_o    = divisor_q;
  assign div_of_o         = of_q;
  assign div_hsp_ref_o    = hsp_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_id_o        = id_q;
  assign resp_quotient_o  = resp_quot_q;
  assign resp_remainder_o = resp_rem_q;
  assign resp_overflow_o  = resp_ovf_q;
  assign resp_hsp_ref_o   = resp_hsp_q;
`ifdef HSID_DIV_ARB_TIMEOUT_EN
  assign resp_timeout_o   = resp_timeout_q;
`else
  assign resp_timeout_o   = 1'b0;
`endif
  assign busy_o           = (state_q != HDA_IDLE);

endmodule
